mux_tt_scanner: RTL and testbench

Truth-table scanner that sequences a four-input, single-output combinational function unit, such as the 8:1-mux-built function block. It drives all 16 input vectors in ascending order, waits a configurable settle time, and samples `y` into a 16-bit captured table. It compares the captured table bit-by-bit against an expected table and reports the mismatch count, the first failing vector, and pass/fail through a start/done handshake.

---
 rtl/mux_tt_scanner_if.sv | 29 ++
 rtl/mux_tt_scanner.sv | 116 +++++++++++
 tb/tb_mux_tt_scanner.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mux_tt_scanner_if.sv
// Bundle between a truth-table scanner and its requester / function unit.
// Requester side (master) drives start, expected and the unit output y;
// scanner side (slave) drives the vector a..d, status and captured results.
interface mux_tt_scanner_if;
  logic        start;
  logic [15:0] expected;
  logic        y;
  logic        a;
  logic        b;
  logic        c;
  logic        d;
  logic        busy;
  logic        done;
  logic [15:0] table_out;
  logic        pass;
  logic [4:0]  err_count;
  logic [3:0]  first_err;
  logic        first_err_valid;

  modport master (
    output start, expected, y,
    input  a, b, c, d, busy, done, table_out, pass, err_count, first_err, first_err_valid
  );

  modport slave (
    input  start, expected, y,
    output a, b, c, d, busy, done, table_out, pass, err_count, first_err, first_err_valid
  );
endinterface

// File: rtl/mux_tt_scanner.sv
// Purpose: walks a 4-input function unit through all 16 vectors, captures y,
//   compares against a latched expected table and reports count/first fail/pass.
// Latency: (SETTLE_CYCLES+1) cycles per vector; done pulses 16*(SETTLE_CYCLES+1)+1
//   cycles after the start edge. Backpressure: none; start is ignored unless idle.
// Ports: clk, rst_n (async active-low), bus (slave modport: start/expected/y in,
//   a..d, busy, done, table_out, pass, err_count, first_err(_valid) out).
module mux_tt_scanner #(
  parameter int SETTLE_CYCLES = 1  // legal range 1..15
) (
  input  logic             clk,
  input  logic             rst_n,
  mux_tt_scanner_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      state;
  logic [3:0]  idx;
  logic [3:0]  cnt;
  logic [15:0] exp_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] table_q;
  logic        pass_q;
  logic [4:0]  err_q;
  logic [3:0]  first_q;
  logic        first_vld_q;

  logic mismatch;
  assign mismatch = (bus.y != exp_q[idx]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= 4'd0;
      cnt         <= 4'd0;
      exp_q       <= 16'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      table_q     <= 16'd0;
      pass_q      <= 1'b0;
      err_q       <= 5'd0;
      first_q     <= 4'd0;
      first_vld_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            exp_q       <= bus.expected;
            table_q     <= 16'd0;
            err_q       <= 5'd0;
            pass_q      <= 1'b0;
            first_q     <= 4'd0;
            first_vld_q <= 1'b0;
            idx         <= 4'd0;
            cnt         <= 4'd0;
            busy_q      <= 1'b1;
            state       <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state <= SAMPLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        SAMPLE: begin
          table_q[idx] <= bus.y;
          if (mismatch) begin
            // At most 16 samples per scan, so 5 bits cannot overflow.
            err_q <= err_q + 5'd1;
            if (!first_vld_q) begin
              first_q     <= idx;
              first_vld_q <= 1'b1;
            end
          end
          if (idx == 4'd15) begin
            busy_q <= 1'b0;
            state  <= DONE;
          end else begin
            idx   <= idx + 4'd1;
            cnt   <= 4'd0;
            state <= SETTLE;
          end
        end
        DONE: begin
          // Two cycles here: the first turns the final err count into pass and
          // raises done; the second drops done. start is ignored throughout,
          // so a held start restarts only from the following IDLE cycle.
          if (!done_q) begin
            done_q <= 1'b1;
            pass_q <= (err_q == 5'd0);
          end else begin
            done_q <= 1'b0;
            idx    <= 4'd0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign {bus.a, bus.b, bus.c, bus.d} = idx;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.table_out       = table_q;
  assign bus.pass            = pass_q;
  assign bus.err_count       = err_q;
  assign bus.first_err       = first_q;
  assign bus.first_err_valid = first_vld_q;

endmodule

// File: tb/tb_mux_tt_scanner.sv
module tb_mux_tt_scanner;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int mode1 = 0;  // 0 golden, 1 stuck-0, 2 stuck-1, 3 golden delayed 2 cycles

  mux_tt_scanner_if bus1();
  mux_tt_scanner_if bus3();

  mux_tt_scanner #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  mux_tt_scanner #(.SETTLE_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  logic [15:0] gold;
  assign gold = 16'h48A5;

  logic [3:0] v1, v3;
  assign v1 = {bus1.a, bus1.b, bus1.c, bus1.d};
  assign v3 = {bus3.a, bus3.b, bus3.c, bus3.d};

  // Function unit model with two register stages of delay.
  logic d1_1, d2_1, d1_3, d2_3;
  always_ff @(posedge clk) begin
    d1_1 <= gold[v1];
    d2_1 <= d1_1;
    d1_3 <= gold[v3];
    d2_3 <= d1_3;
  end

  always_comb begin
    bus1.y = 1'b0;
    case (mode1)
      0:       bus1.y = gold[v1];
      1:       bus1.y = 1'b0;
      2:       bus1.y = 1'b1;
      default: bus1.y = d2_1;
    endcase
  end
  assign bus3.y = d2_3;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int misc1();
    return int'({bus1.a, bus1.b, bus1.c, bus1.d, bus1.busy, bus1.done, bus1.pass,
                 bus1.err_count, bus1.first_err, bus1.first_err_valid});
  endfunction

  // Pulses start on bus1, then follows the scan until done; k counts cycles
  // after the start edge, so vector k/2 must be on a..d in busy cycle k.
  task automatic scan1(input logic [15:0] e, output int lat, output int busy_n,
                       output int seq_bad);
    int k;
    busy_n  = 0;
    seq_bad = 0;
    repeat (3) @(negedge clk);
    bus1.expected = e;
    bus1.start    = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    k = 0;
    while (!bus1.done && k < 200) begin
      if (bus1.busy) begin
        busy_n++;
        if ({bus1.a, bus1.b, bus1.c, bus1.d} != 4'(k / 2)) seq_bad++;
      end
      @(negedge clk);
      k++;
    end
    lat = k;
  endtask

  typedef struct {
    logic [15:0] exp_in;
    int          mode;
    logic [15:0] tab;
    int          err;
    int          fe;
    int          fev;
    int          pass;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int lat, busy_n, seq_bad, k, dones, done_k, dn1, dn2, rise;

    vecs[0] = '{16'h48A5, 0, 16'h48A5,  0,  0, 0, 1};
    vecs[1] = '{16'h48A4, 0, 16'h48A5,  1,  0, 1, 0};
    vecs[2] = '{16'hFFFF, 1, 16'h0000, 16,  0, 1, 0};
    vecs[3] = '{16'h0000, 2, 16'hFFFF, 16,  0, 1, 0};
    vecs[4] = '{16'hFFFF, 2, 16'hFFFF,  0,  0, 0, 1};
    vecs[5] = '{16'hC8A5, 0, 16'h48A5,  1, 15, 1, 0};
    vecs[6] = '{16'h0000, 0, 16'h48A5,  6,  0, 1, 0};
    vecs[7] = '{16'h48A5, 1, 16'h0000,  6,  0, 1, 0};
    vecs[8] = '{16'h48B5, 0, 16'h48A5,  1,  4, 1, 0};

    bus1.start = 1'b0; bus1.expected = 16'h0;
    bus3.start = 1'b0; bus3.expected = 16'h0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset_tab", int'(bus1.table_out), 0);
    check("reset_misc", misc1(), 0);
    check("reset_dut3", int'({bus3.table_out, bus3.busy, bus3.done, bus3.pass}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table-driven full scans on the SETTLE_CYCLES=1 instance.
    for (int i = 0; i < 9; i++) begin
      mode1 = vecs[i].mode;
      scan1(vecs[i].exp_in, lat, busy_n, seq_bad);
      check($sformatf("v%0d_latency", i), lat, 33);
      check($sformatf("v%0d_busy_cycles", i), busy_n, 32);
      check($sformatf("v%0d_vector_seq", i), seq_bad, 0);
      check($sformatf("v%0d_table", i), int'(bus1.table_out), int'(vecs[i].tab));
      check($sformatf("v%0d_err_count", i), int'(bus1.err_count), vecs[i].err);
      check($sformatf("v%0d_first_err", i), int'(bus1.first_err), vecs[i].fe);
      check($sformatf("v%0d_first_valid", i), int'(bus1.first_err_valid), vecs[i].fev);
      check($sformatf("v%0d_pass", i), int'(bus1.pass), vecs[i].pass);
    end
    mode1 = 0;

    // start pulsed in SETTLE and in the done cycle, expected toggled mid-scan.
    repeat (3) @(negedge clk);
    bus1.expected = 16'h48A5;
    bus1.start    = 1'b1;
    @(negedge clk);
    dones = 0; done_k = -1; busy_n = 0;
    for (int kk = 0; kk < 100; kk++) begin
      bus1.start = (kk == 5) || (kk == 33);
      if (kk == 10) bus1.expected = 16'hB75A;
      if (bus1.done) begin
        dones++;
        if (done_k < 0) done_k = kk;
      end
      if (bus1.busy) busy_n++;
      @(negedge clk);
    end
    bus1.start = 1'b0;
    check("hs_done_count", dones, 1);
    check("hs_done_cycle", done_k, 33);
    check("hs_busy_cycles", busy_n, 32);
    check("hs_pass_latched_exp", int'(bus1.pass), 1);
    check("hs_err_latched_exp", int'(bus1.err_count), 0);

    // start held high: back-to-back scans with one idle cycle in between.
    repeat (3) @(negedge clk);
    bus1.expected = 16'h48A5;
    bus1.start    = 1'b1;
    @(negedge clk);
    dn1 = -1; dn2 = -1; rise = -1;
    for (int kk = 0; kk < 80; kk++) begin
      if (bus1.done) begin
        if (dn1 < 0) dn1 = kk;
        else if (dn2 < 0) dn2 = kk;
      end
      if (dn1 >= 0 && rise < 0 && bus1.busy) rise = kk;
      @(negedge clk);
    end
    bus1.start = 1'b0;
    check("held_first_done", dn1, 33);
    check("held_restart_busy", rise, 35);
    check("held_second_done", dn2, 68);
    k = 0;
    while (!bus1.done && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("held_drain_done", int'(bus1.done), 1);
    check("held_done_width", int'(bus1.pass), 1);
    @(negedge clk);
    check("held_done_drops", int'(bus1.done), 0);

    // Reset in the middle of vector 7.
    repeat (3) @(negedge clk);
    bus1.expected = 16'h0000;
    bus1.start    = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (14) @(negedge clk);
    check("mid_vector", int'(v1), 7);
    check("mid_err_count", int'(bus1.err_count), 3);
    check("mid_busy", int'(bus1.busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_tab", int'(bus1.table_out), 0);
    check("mid_reset_misc", misc1(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    scan1(16'h48A5, lat, busy_n, seq_bad);
    check("post_reset_latency", lat, 33);
    check("post_reset_table", int'(bus1.table_out), 16'h48A5);
    check("post_reset_pass", int'(bus1.pass), 1);

    // Slow function unit: too short a settle time captures the previous vector.
    mode1 = 3;
    scan1(16'h48A5, lat, busy_n, seq_bad);
    check("slow_s1_pass", int'(bus1.pass), 0);
    check("slow_s1_table", int'(bus1.table_out), 16'h914B);
    check("slow_s1_err_count", int'(bus1.err_count), 11);
    check("slow_s1_first_err", int'(bus1.first_err), 1);
    mode1 = 0;

    repeat (3) @(negedge clk);
    bus3.expected = 16'h48A5;
    bus3.start    = 1'b1;
    @(negedge clk);
    bus3.start = 1'b0;
    k = 0;
    while (!bus3.done && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("slow_s3_latency", k, 65);
    check("slow_s3_pass", int'(bus3.pass), 1);
    check("slow_s3_table", int'(bus3.table_out), 16'h48A5);
    check("slow_s3_err_count", int'(bus3.err_count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
